// File: rtl/mfm_pll.sv
// mfm_pll: digital PLL / data separator for a 2 us MFM read stream.
// Tracks cell phase and period from flux pulses; emits a cell strobe, the cell's data bit and a lock flag.
module mfm_pll #(
    parameter int CELL_TICKS = 32,
    parameter int PER_TOL    = 3,
    parameter int LOCK_TOL   = 2,
    parameter int LOCK_COUNT = 8,
    parameter int MISS_CELLS = 4
) (
    input  logic clk_k,
    input  logic rst,
    input  logic clk_id,
    input  logic din,
    output logic cout,
    output logic dout,
    output logic lck
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MISS_CELLS + 1);
    localparam logic [5:0]        PER_NOM = 6'(CELL_TICKS);
    localparam logic [5:0]        PER_MIN = 6'(CELL_TICKS - PER_TOL);
    localparam logic [5:0]        PER_MAX = 6'(CELL_TICKS + PER_TOL);
    localparam logic signed [7:0] HALF    = 8'(CELL_TICKS / 2);
    localparam logic [7:0]        TOL     = 8'(LOCK_TOL);

    logic          clk_id_q;
    logic [2:0]    din_sync;
    logic [5:0]    cnt, period;
    logic          hit;
    logic [GW-1:0] good_cnt;
    logic [MW-1:0] miss_cnt;

    logic              tick, pulse_evt, wrap;
    logic signed [7:0] err, base, adj;
    logic [7:0]        err_abs;
    logic [5:0]        cnt_fix, last;

    assign tick      = clk_id & ~clk_id_q;
    assign pulse_evt = din_sync[1] & ~din_sync[2];
    assign last      = period - 6'd1;
    // >= rather than == so a period shrink below the current count still wraps
    assign wrap      = tick & (cnt >= last);
    assign err       = $signed({2'b00, cnt}) - HALF;
    assign err_abs   = err[7] ? $unsigned(-err) : $unsigned(err);
    assign base      = wrap ? 8'sd0 : $signed({2'b00, cnt + {5'd0, tick}});
    assign adj       = base - (err >>> 2);

    always_comb begin
        cnt_fix = adj[5:0];
        if (adj[7])
            cnt_fix = 6'd0;
        else if (adj > $signed({2'b00, last}))
            cnt_fix = last;
    end

    always_ff @(posedge clk_k) begin
        if (rst) begin
            clk_id_q <= 1'b0;
            din_sync <= '0;
            cnt      <= '0;
            period   <= PER_NOM;
            hit      <= 1'b0;
            good_cnt <= '0;
            miss_cnt <= '0;
            cout     <= 1'b0;
            dout     <= 1'b0;
            lck      <= 1'b0;
        end else begin
            clk_id_q <= clk_id;
            din_sync <= {din_sync[1:0], din};
            cout     <= wrap;

            if (pulse_evt)
                cnt <= cnt_fix;
            else if (wrap)
                cnt <= '0;
            else if (tick)
                cnt <= cnt + 6'd1;

            // an event on the wrap cycle already belongs to the new cell
            if (wrap) begin
                dout <= hit;
                hit  <= pulse_evt;
            end else if (pulse_evt) begin
                hit <= 1'b1;
            end

            if (pulse_evt) begin
                if (err > 0 && period < PER_MAX)
                    period <= period + 6'd1;
                else if (err < 0 && period > PER_MIN)
                    period <= period - 6'd1;
                if (err_abs <= TOL) begin
                    if (good_cnt < GW'(LOCK_COUNT))
                        good_cnt <= good_cnt + GW'(1);
                    if (good_cnt >= GW'(LOCK_COUNT - 1))
                        lck <= 1'b1;
                end else begin
                    good_cnt <= '0;
                    lck      <= 1'b0;
                end
            end

            // a dropout outranks a good edge landing on the same cycle
            if (wrap) begin
                if (hit) begin
                    miss_cnt <= '0;
                end else begin
                    if (miss_cnt < MW'(MISS_CELLS))
                        miss_cnt <= miss_cnt + MW'(1);
                    if (miss_cnt >= MW'(MISS_CELLS - 1)) begin
                        lck      <= 1'b0;
                        good_cnt <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mfm_pll.sv
// tb_mfm_pll: randomized MFM pulse streams against a cell-level reference model.
// The model queues each expected cell strobe; a monitor pops and compares when the DUT strobes.
module tb_mfm_pll;
    localparam int CELL = 32;

    logic clk_k = 1'b0, rst = 1'b1, clk_id = 1'b0, din = 1'b0;
    logic cout, dout, lck;

    mfm_pll dut (
        .clk_k (clk_k),
        .rst   (rst),
        .clk_id(clk_id),
        .din   (din),
        .cout  (cout),
        .dout  (dout),
        .lck   (lck)
    );

    initial forever #5 clk_k = ~clk_k;
    initial forever begin
        @(negedge clk_k);
        clk_id = ~clk_id;
    end

    int n_chk = 0, n_fail = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int cyc;
        bit d;
        bit l;
    } exp_t;
    exp_t sbq[$];

    // Reference model: a tick-level view of the cell clock with integer arithmetic.
    int m_idq = 0, m_h0 = 0, m_h1 = 0, m_h2 = 0;
    int m_cnt = 0, m_per = CELL, m_hit = 0, m_lck = 0, m_good = 0, m_miss = 0;

    task automatic model_step(input logic r, input logic cid, input logic d);
        int tk, ev, wr, err, nc;
        exp_t x;
        if (r === 1'b1) begin
            m_idq = 0; m_h0 = 0; m_h1 = 0; m_h2 = 0;
            m_cnt = 0; m_per = CELL; m_hit = 0; m_lck = 0; m_good = 0; m_miss = 0;
            return;
        end
        tk = (cid && m_idq == 0) ? 1 : 0;
        ev = (m_h1 == 1 && m_h2 == 0) ? 1 : 0;
        m_idq = cid; m_h2 = m_h1; m_h1 = m_h0; m_h0 = d;
        wr  = (tk == 1 && m_cnt >= m_per - 1) ? 1 : 0;
        err = m_cnt - CELL / 2;
        nc  = (wr == 1) ? 0 : m_cnt + tk;
        if (ev == 1) begin
            nc = nc - ((err >= 0) ? err / 4 : -((3 - err) / 4));
            if (nc < 0) nc = 0;
            if (nc > m_per - 1) nc = m_per - 1;
            if (err > 0 && m_per < CELL + 3) m_per = m_per + 1;
            if (err < 0 && m_per > CELL - 3) m_per = m_per - 1;
            if (err >= -2 && err <= 2) begin
                if (m_good < 8) m_good++;
                if (m_good >= 8) m_lck = 1;
            end else begin
                m_good = 0;
                m_lck  = 0;
            end
        end
        m_cnt = nc;
        if (wr == 1) begin
            x.cyc = cyc;
            x.d   = (m_hit == 1);
            if (m_hit == 1) m_miss = 0;
            else begin
                if (m_miss < 4) m_miss++;
                if (m_miss >= 4) begin
                    m_lck  = 0;
                    m_good = 0;
                end
            end
            m_hit = ev;
            x.l   = (m_lck == 1);
            sbq.push_back(x);
        end else if (ev == 1) begin
            m_hit = 1;
        end
    endtask

    initial forever begin
        @(posedge clk_k);
        cyc++;
        model_step(rst, clk_id, din);
    end

    // Monitor: pops an expectation whenever the DUT strobes, tracks lck every cycle.
    int last_c = -1, prev_c = -1, n_cout = 0;
    bit dq[$];
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_k);
            if (cyc > 0) begin
                check("lck_track", lck, m_lck);
                if (cout === 1'b1) begin
                    n_cout++;
                    prev_c = last_c;
                    last_c = cyc;
                    dq.push_back(dout);
                    if (sbq.size() == 0) begin
                        check("cout_unexpected", cout, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("dout", dout, e.d);
                        check("lck_at_cout", lck, e.l);
                    end
                end else if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check("cout_missing", cout, 1);
                end
            end
        end
    end

    int pat[16] = '{1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0};

    // mode 0: no pulses, 1: pulse every slot, 2: sync pattern starting at pidx
    task automatic cells(input int gap, input int n, input int mode, input int pidx);
        for (int s = 0; s < n; s++) begin
            bit b;
            int w;
            b = (mode == 1) || (mode == 2 && pat[(pidx + s) % 16] == 1);
            w = $urandom_range(2, 6);
            for (int c = 0; c < gap; c++) begin
                @(negedge clk_k);
                din = b && c >= 35 && c < 35 + w;
            end
        end
    endtask

    task automatic wait_couts(input int k, output bit ok);
        int tgt;
        tgt = n_cout + k;
        ok  = 1'b0;
        for (int i = 0; i < 200 * k && !ok; i++) begin
            @(negedge clk_k);
            #1;
            if (n_cout >= tgt) ok = 1'b1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, found;
        int rel, d, b0;

        rst = 1'b1;
        @(posedge clk_k);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_k);
            din = 1'($urandom_range(0, 1));
            check("rst_cout", cout, 0);
            check("rst_dout", dout, 0);
            check("rst_lck", lck, 0);
        end

        @(negedge clk_k);
        rst = 1'b0;
        din = 1'b0;
        rel = cyc + 1;
        wait_couts(1, ok);
        check("first_cout_seen", ok, 1);
        d = last_c - rel;
        check("first_cout_delay_62_63", (d >= 62 && d <= 63), 1);

        for (int i = 0; i < 3; i++) begin
            wait_couts(1, ok);
            check("freerun_cout_seen", ok, 1);
            check("freerun_period", last_c - prev_c, 64);
            check("freerun_dout", dout, 0);
            check("freerun_lck", lck, 0);
        end

        // sync word at a random phase; the last 16 cells must spell a rotation of it
        repeat ($urandom_range(0, 63)) @(negedge clk_k);
        dq.delete();
        cells(64, 64, 2, $urandom_range(0, 15));
        found = 1'b0;
        if (dq.size() >= 16) begin
            b0 = dq.size() - 16;
            for (int r = 0; r < 16; r++) begin
                bit m;
                m = 1'b1;
                for (int i = 0; i < 16; i++)
                    if (int'(dq[b0 + i]) != pat[(r + i) % 16]) m = 1'b0;
                if (m) found = 1'b1;
            end
        end
        check("sync_pattern_rotation", found, 1);

        repeat ($urandom_range(0, 63)) @(negedge clk_k);
        cells(64, 60, 1, 0);
        check("lock_64", lck, 1);

        cells(64, 4, 0, 0);
        repeat (34) @(negedge clk_k);
        check("dropout_lck", lck, 0);
        cells(64, 60, 1, 0);
        check("relock_after_dropout", lck, 1);

        repeat (12) @(negedge clk_k);
        cells(64, 1, 1, 0);
        check("phase_step_drop", lck, 0);
        cells(64, 60, 1, 0);
        check("phase_step_relock", lck, 1);

        cells(62, 80, 1, 0);
        check("lock_62", lck, 1);
        check("period_62", last_c - prev_c, 62);

        cells(74, 40, 1, 0);
        check("nolock_74", lck, 0);

        repeat (20) @(negedge clk_k);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_k);
            check("midrst_cout", cout, 0);
            check("midrst_lck", lck, 0);
            check("midrst_dout", dout, 0);
        end
        rst = 1'b0;
        rel = cyc + 1;
        wait_couts(1, ok);
        check("midrst_cout_seen", ok, 1);
        d = last_c - rel;
        check("midrst_first_cout_62_63", (d >= 62 && d <= 63), 1);

        repeat (10) @(negedge clk_k);
        check("scoreboard_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
